// File: rtl/strip_alloc_ctrl.sv
// Strip allocation controller: maps request height to a ROM address, picks the first
// candidate strip with enough free width and tracks per-strip remaining width.
module strip_alloc_ctrl #(
   parameter int unsigned NUM_STRIPS = 13,
   parameter int unsigned STRIP_W    = 16,
   parameter int unsigned WW         = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [4:0]    req_height,
   input  logic [WW-1:0] req_width,
   output logic [3:0]    rom_addr,
   input  logic [3:0]    rom_id1,
   input  logic [3:0]    rom_id2,
   input  logic [3:0]    rom_id3,
   output logic          rsp_valid,
   output logic          rsp_ok,
   output logic [3:0]    rsp_strip,
   output logic [WW-1:0] rsp_xoff,
   input  logic          rel_valid,
   input  logic [3:0]    rel_strip,
   input  logic [WW-1:0] rel_width
);

   localparam logic [3:0]    InvalidId = 4'hD;
   localparam logic [WW-1:0] StripW    = WW'(STRIP_W);
   localparam logic [WW:0]   StripWExt = (WW+1)'(STRIP_W);

   typedef enum logic [1:0] {StIdle, StLookup, StCheck, StResp} state_e;

   state_e        state_q, state_d;
   logic          req_ready_q, req_ready_d;
   logic [3:0]    rom_addr_q, rom_addr_d;
   logic [WW-1:0] width_q, width_d;
   logic          illegal_q, illegal_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_ok_q, rsp_ok_d;
   logic [3:0]    rsp_strip_q, rsp_strip_d;
   logic [WW-1:0] rsp_xoff_q, rsp_xoff_d;
   logic [WW-1:0] rem_q [NUM_STRIPS];
   logic [WW-1:0] rem_d [NUM_STRIPS];

   logic [3:0]    cand [3];
   logic          grant, do_grant, hit;
   logic [3:0]    grant_id;
   logic [WW-1:0] grant_rem, c_rem;
   logic [WW:0]   sum;

   assign cand[0] = rom_id1;
   assign cand[1] = rom_id2;
   assign cand[2] = rom_id3;

   // Priority pick over the three ROM candidates, using the table as it stands this cycle.
   always_comb begin
      grant     = 1'b0;
      grant_id  = InvalidId;
      grant_rem = '0;
      hit       = 1'b0;
      c_rem     = '0;
      for (int k = 0; k < 3; k++) begin
         hit   = 1'b0;
         c_rem = '0;
         for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
            if (cand[k] == 4'(i)) begin
               hit   = 1'b1;
               c_rem = rem_q[i];
            end
         end
         if (!grant && hit && cand[k] != InvalidId && c_rem >= width_q) begin
            grant     = 1'b1;
            grant_id  = cand[k];
            grant_rem = c_rem;
         end
      end
   end

   assign do_grant = (state_q == StCheck) && grant && !illegal_q;

   always_comb begin
      state_d     = state_q;
      rom_addr_d  = rom_addr_q;
      width_d     = width_q;
      illegal_d   = illegal_q;
      rsp_valid_d = 1'b0;
      rsp_ok_d    = rsp_ok_q;
      rsp_strip_d = rsp_strip_q;
      rsp_xoff_d  = rsp_xoff_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               state_d   = StLookup;
               width_d   = req_width;
               illegal_d = (req_width == '0) || ({1'b0, req_width} > StripWExt);
               if (req_height < 5'd4 || req_height > 5'd16) begin
                  rom_addr_d = 4'd0;
                  illegal_d  = 1'b1;
               end else if (req_height <= 5'd12) begin
                  rom_addr_d = 4'(req_height - 5'd4);
               end else begin
                  rom_addr_d = 4'd9;
               end
            end
         end
         StLookup: state_d = StCheck;
         StCheck: begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_ok_d    = do_grant;
            rsp_strip_d = do_grant ? grant_id : InvalidId;
            rsp_xoff_d  = do_grant ? StripW - grant_rem : '0;
         end
         StResp: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      req_ready_d = (state_d == StIdle);
   end

   // Grant subtracts first, release adds and saturates; one extra bit keeps the sum exact.
   always_comb begin
      sum = '0;
      for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
         sum = {1'b0, rem_q[i]};
         if (do_grant && grant_id == 4'(i)) begin
            sum = sum - {1'b0, width_q};
         end
         if (rel_valid && rel_strip == 4'(i) && rel_strip != InvalidId) begin
            sum = sum + {1'b0, rel_width};
         end
         if (sum > StripWExt) begin
            sum = StripWExt;
         end
         rem_d[i] = sum[WW-1:0];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         req_ready_q <= 1'b1;
         rom_addr_q  <= 4'd0;
         width_q     <= '0;
         illegal_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_ok_q    <= 1'b0;
         rsp_strip_q <= InvalidId;
         rsp_xoff_q  <= '0;
         for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
            rem_q[i] <= StripW;
         end
      end else begin
         state_q     <= state_d;
         req_ready_q <= req_ready_d;
         rom_addr_q  <= rom_addr_d;
         width_q     <= width_d;
         illegal_q   <= illegal_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_ok_q    <= rsp_ok_d;
         rsp_strip_q <= rsp_strip_d;
         rsp_xoff_q  <= rsp_xoff_d;
         for (int unsigned i = 0; i < NUM_STRIPS; i++) begin
            rem_q[i] <= rem_d[i];
         end
      end
   end

   assign req_ready = req_ready_q;
   assign rom_addr  = rom_addr_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_ok    = rsp_ok_q;
   assign rsp_strip = rsp_strip_q;
   assign rsp_xoff  = rsp_xoff_q;

endmodule
